// File: rtl/sram_arb_pkg.sv
// Shared types for the round-robin SRAM arbiter: command and read-tag records
// plus the default geometry used by the top-level parameters.
package sram_arb_pkg;

  localparam int ADDR_W_D = 4;
  localparam int DATA_W_D = 8;
  localparam int NREQ_MAX = 4;
  localparam int ID_W     = $clog2(NREQ_MAX);

  typedef struct packed {
    logic                we;
    logic [ADDR_W_D-1:0] addr;
    logic [DATA_W_D-1:0] wdata;
    logic [ID_W-1:0]     id;
  } cmd_t;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first valid requester at or after prio,
// scanning upward modulo NREQ.
module rr_grant
  import sram_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] prio,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  // Scan from the farthest offset down so the nearest valid requester wins last.
  always_comb begin
    int idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(prio) + k) % NREQ;
      if (valid[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Shares one single-port SRAM among NREQ valid/ready requesters; reads return
// a tagged one-cycle response three cycles after acceptance.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   mem_wren,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_d_in,
  input  logic [DATA_W-1:0]      mem_d_out
);

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  logic              accept;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ID_W-1:0]   prio_q, prio_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  tag_t              tag_cmd_q, tag_cmd_d;
  tag_t              tag_s1_q, tag_s1_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  rr_grant #(.NREQ(NREQ)) u_grant (
    .valid  (req_valid),
    .prio   (prio_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  assign accept    = gnt_any & ~rst;
  assign req_ready = rst ? '0 : gnt;

  // One-hot grant lets the command mux collapse to an AND-OR tree.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_we    = sel_we | req_we[i];
        sel_addr  = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    prio_d      = prio_q;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    tag_cmd_d   = '0;
    tag_s1_d    = tag_cmd_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;

    if (accept) begin
      prio_d       = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
      wren_d       = sel_we;
      addr_d       = sel_addr;
      din_d        = sel_wdata;
      tag_cmd_d.v  = ~sel_we;
      tag_cmd_d.id = gnt_id;
    end

    // SRAM output for the read in stage 1 is valid now; capture it with its tag.
    if (tag_s1_q.v) begin
      rsp_data_d = mem_d_out;
      for (int i = 0; i < NREQ; i++) begin
        rsp_valid_d[i] = (tag_s1_q.id == ID_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      tag_cmd_q   <= '0;
      tag_s1_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      prio_q      <= prio_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      tag_cmd_q   <= tag_cmd_d;
      tag_s1_q    <= tag_s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mem_wren  = wren_q;
  assign mem_addr  = addr_q;
  assign mem_d_in  = din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural single-port SRAM
// preloaded so that mem[a] = {a,a}.
module tb_sram_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        mem_wren;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_d_in;
  logic [7:0]  mem_d_out;
  logic [7:0]  sram [16];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.NREQ(2), .ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_d_in  (mem_d_in),
    .mem_d_out (mem_d_out)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) sram[i] <= 8'(i * 17);
    end else if (mem_wren) begin
      sram[mem_addr] <= mem_d_in;
    end
    if (!mem_wren) mem_d_out <= sram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [3:0] a, input logic [7:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_addr[i*4 +: 4]   = a;
    req_wdata[i*8 +: 8]  = d;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] v, input logic [7:0] d);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(v));
    if (v != 2'b00) chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(d));
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    step; step;
    // Reset state, with valids asserted to show the grant is masked
    step; preload = 1'b0; req_valid = 2'b11; #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_wren", 32'(mem_wren), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_din", 32'(mem_d_in), 32'h0);
    step; rst = 1'b0; req_valid = '0;
    $display("reset released");

    // Single write then read by r0
    step; set_req(0, 1, 1, 4'd3, 8'hA5); #1; chk("wr_ready", 32'(req_ready), 32'h1);
    step; set_req(0, 0, 0, 4'd0, 8'h00); #1;
    chk("wr_wren", 32'(mem_wren), 32'h1);
    chk("wr_addr", 32'(mem_addr), 32'h3);
    chk("wr_din", 32'(mem_d_in), 32'hA5);
    step; set_req(0, 1, 0, 4'd3, 8'h00); #1;
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("idle_wren", 32'(mem_wren), 32'h0);
    chk("idle_addr_hold", 32'(mem_addr), 32'h3);
    chk("idle_din_hold", 32'(mem_d_in), 32'hA5);
    step; set_req(0, 0, 0, 4'd0, 8'h00); #1;
    chk("rd_wren", 32'(mem_wren), 32'h0);
    chk("rd_addr", 32'(mem_addr), 32'h3);
    step; #1; chk_rsp("rd_early", 2'b00, 8'h00);
    step; #1; chk_rsp("rd_resp", 2'b01, 8'hA5);
    step; #1; chk_rsp("rd_after", 2'b00, 8'h00);
    $display("single write/read: rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);

    // Contention after reset: alternating grants, alternating responses
    rst = 1'b1; step; step; rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step;
      if (k < 4) begin
        set_req(0, 1, 0, 4'd1, 8'h00);
        set_req(1, 1, 0, 4'd2, 8'h00);
      end else begin
        req_valid = 2'b00;
      end
      #1;
      chk($sformatf("cont_ready_%0d", k), 32'(req_ready),
          (k < 4) ? ((k % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      if (k >= 3 && k < 7)
        chk_rsp($sformatf("cont_%0d", k), ((k - 3) % 2 == 0) ? 2'b01 : 2'b10,
                ((k - 3) % 2 == 0) ? 8'h11 : 8'h22);
      else
        chk_rsp($sformatf("cont_%0d", k), 2'b00, 8'h00);
      $display("contention cycle %0d: ready=%b rsp_valid=%b rsp_data=%h",
               k, req_ready, rsp_valid, rsp_data);
    end

    // Read-after-write across requesters on back-to-back cycles
    step; set_req(0, 1, 1, 4'd5, 8'h3C); #1; chk("raw_wr_ready", 32'(req_ready), 32'h1);
    step; set_req(0, 0, 0, 4'd0, 8'h00); set_req(1, 1, 0, 4'd5, 8'h00); #1;
    chk("raw_rd_ready", 32'(req_ready), 32'h2);
    step; set_req(1, 0, 0, 4'd0, 8'h00); #1; chk_rsp("raw_t2", 2'b00, 8'h00);
    step; #1; chk_rsp("raw_t3", 2'b00, 8'h00);
    step; #1; chk_rsp("raw_t4", 2'b10, 8'h3C);
    $display("raw: rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);

    // Back-pressure: r1 holds its command while r0 is served
    step; set_req(0, 1, 1, 4'd9, 8'h5A); set_req(1, 1, 1, 4'd10, 8'hC3); #1;
    chk("bp_ready0", 32'(req_ready), 32'h1);
    step; set_req(0, 0, 0, 4'd0, 8'h00); #1;
    chk("bp_ready1", 32'(req_ready), 32'h2);
    chk("bp_wr0_addr", 32'(mem_addr), 32'h9);
    chk("bp_wr0_din", 32'(mem_d_in), 32'h5A);
    step; set_req(1, 0, 0, 4'd0, 8'h00); #1;
    chk("bp_ready_none", 32'(req_ready), 32'h0);
    chk("bp_wr1_wren", 32'(mem_wren), 32'h1);
    chk("bp_wr1_addr", 32'(mem_addr), 32'hA);
    chk("bp_wr1_din", 32'(mem_d_in), 32'hC3);
    $display("backpressure: addr=%h d_in=%h", mem_addr, mem_d_in);

    // Reset mid-flight: reads in flight dropped, write under reset discarded
    step; set_req(1, 1, 0, 4'd2, 8'h00); #1; chk("mf_ready_r1", 32'(req_ready), 32'h2);
    step; set_req(1, 0, 0, 4'd0, 8'h00); set_req(0, 1, 0, 4'd3, 8'h00); #1;
    chk("mf_ready_r0", 32'(req_ready), 32'h1);
    step; rst = 1'b1; set_req(0, 1, 1, 4'd7, 8'hFF); #1;
    chk("mf_ready_rst", 32'(req_ready), 32'h0);
    step; #1;
    chk("mf_rst_ready", 32'(req_ready), 32'h0);
    chk_rsp("mf_rst", 2'b00, 8'h00);
    chk("mf_rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("mf_rst_wren", 32'(mem_wren), 32'h0);
    chk("mf_rst_addr", 32'(mem_addr), 32'h0);
    chk("mf_rst_din", 32'(mem_d_in), 32'h0);
    step; rst = 1'b0; set_req(0, 1, 0, 4'd7, 8'h00); set_req(1, 1, 0, 4'd6, 8'h00); #1;
    chk("mf_first_grant", 32'(req_ready), 32'h1);
    chk_rsp("mf_r4", 2'b00, 8'h00);
    step; set_req(0, 0, 0, 4'd0, 8'h00); #1;
    chk("mf_second_grant", 32'(req_ready), 32'h2);
    chk_rsp("mf_r5", 2'b00, 8'h00);
    step; set_req(1, 0, 0, 4'd0, 8'h00); #1; chk_rsp("mf_r6", 2'b00, 8'h00);
    step; #1; chk_rsp("mf_old7", 2'b01, 8'h77);
    step; #1; chk_rsp("mf_old6", 2'b10, 8'h66);
    $display("reset mid-flight: rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
